// File: rtl/dmi_pkg.sv
// Shared DMI constants: channel assignments and legal parameter ranges
// for the event synchroniser.
package dmi_pkg;

    localparam int DMI_CH_RD       = 0;
    localparam int DMI_CH_WR       = 1;

    localparam int SYNC_STAGES_MIN = 2;
    localparam int SYNC_STAGES_MAX = 4;

    localparam int NUM_CH_MIN      = 1;
    localparam int NUM_CH_MAX      = 16;

endpackage

// File: rtl/dmi_sync_chain.sv
// Single-bit multi-flop synchroniser for one TCK-domain level entering
// the core clock domain.
module dmi_sync_chain
    import dmi_pkg::*;
#(
    parameter int STAGES = SYNC_STAGES_MIN
) (
    input  logic clk,
    input  logic rst,
    input  logic i_d,
    output logic o_q
);

    (* ASYNC_REG = "TRUE" *) logic [STAGES-1:0] r_sync;

    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value; blocking here would collapse the chain.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[STAGES-2:0], i_d};
        end
    end

    assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/dmi_cdc_event_sync.sv
// Multi-channel TCK->core event synchroniser with pending/ack handshake,
// lowest-index priority and sticky overflow. Define DMI_CDC_TOGGLE_MODE_EN
// to treat every input transition as an event instead of rising edges only.
module dmi_cdc_event_sync
    import dmi_pkg::*;
#(
    parameter int  NUM_CH      = 2,
    parameter int  SYNC_STAGES = 2,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] async_in,
    output logic              evt_valid,
    output logic [CH_W-1:0]   evt_ch,
    input  logic              evt_ack,
    output logic [NUM_CH-1:0] pend,
    output logic [NUM_CH-1:0] ovf,
    input  logic              ovf_clr
);

    if (SYNC_STAGES < SYNC_STAGES_MIN || SYNC_STAGES > SYNC_STAGES_MAX) begin : g_bad_stages
        $error("dmi_cdc_event_sync: SYNC_STAGES=%0d outside %0d..%0d",
               SYNC_STAGES, SYNC_STAGES_MIN, SYNC_STAGES_MAX);
    end

    if (NUM_CH < NUM_CH_MIN || NUM_CH > NUM_CH_MAX) begin : g_bad_num_ch
        $error("dmi_cdc_event_sync: NUM_CH=%0d outside %0d..%0d",
               NUM_CH, NUM_CH_MIN, NUM_CH_MAX);
    end

    logic [NUM_CH-1:0] w_sync;
    logic [NUM_CH-1:0] r_dly;
    logic [NUM_CH-1:0] w_evt;
    logic [NUM_CH-1:0] w_ack_hit;
    logic [NUM_CH-1:0] r_pend;
    logic [NUM_CH-1:0] r_ovf;
    logic [NUM_CH-1:0] w_pend_nxt;
    logic [NUM_CH-1:0] w_ovf_nxt;
    logic              w_valid;
    logic [CH_W-1:0]   w_ch;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        dmi_sync_chain #(
            .STAGES (SYNC_STAGES)
        ) u_sync (
            .clk (clk),
            .rst (rst),
            .i_d (async_in[g]),
            .o_q (w_sync[g])
        );
    end

`ifdef DMI_CDC_TOGGLE_MODE_EN
    assign w_evt = w_sync ^ r_dly;
`else
    assign w_evt = w_sync & ~r_dly;
`endif

    // Fixed priority: scanning downward leaves the lowest pending index.
    always_comb begin
        w_valid = |r_pend;
        w_ch    = '0;
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (r_pend[i]) begin
                w_ch = CH_W'(i);
            end
        end
    end

    always_comb begin
        w_ack_hit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_ack_hit[i] = evt_ack & w_valid & (w_ch == CH_W'(i));
        end
    end

    // NOTE: every combinational output is given a default before any
    // conditional update, so no path leaves it unassigned and no latch forms.
    always_comb begin
        w_pend_nxt = r_pend;
        w_ovf_nxt  = r_ovf;
        if (ovf_clr) begin
            w_ovf_nxt = '0;
        end
        for (int i = 0; i < NUM_CH; i++) begin
            if (w_evt[i]) begin
                // A fresh event on a channel being acked replaces it cleanly.
                if (r_pend[i] && !w_ack_hit[i]) begin
                    w_ovf_nxt[i] = 1'b1;
                end
                w_pend_nxt[i] = 1'b1;
            end else if (w_ack_hit[i]) begin
                w_pend_nxt[i] = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_dly  <= '0;
            r_pend <= '0;
            r_ovf  <= '0;
        end else begin
            r_dly  <= w_sync;
            r_pend <= w_pend_nxt;
            r_ovf  <= w_ovf_nxt;
        end
    end

    assign evt_valid = w_valid;
    assign evt_ch    = w_ch;
    assign pend      = r_pend;
    assign ovf       = r_ovf;

endmodule

// File: tb/tb_dmi_cdc_event_sync.sv
// Directed self-checking bench for dmi_cdc_event_sync (4 channels, 2 stages),
// with expectations adjusted when DMI_CDC_TOGGLE_MODE_EN is defined.
module tb_dmi_cdc_event_sync;

    localparam int NUM_CH      = 4;
    localparam int SYNC_STAGES = 2;
    localparam int CH_W        = 2;

    logic              clk;
    logic              rst;
    logic [NUM_CH-1:0] async_in;
    logic              evt_valid;
    logic [CH_W-1:0]   evt_ch;
    logic              evt_ack;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] ovf;
    logic              ovf_clr;

    int n_cmp;
    int n_err;

    dmi_cdc_event_sync #(
        .NUM_CH      (NUM_CH),
        .SYNC_STAGES (SYNC_STAGES)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .async_in  (async_in),
        .evt_valid (evt_valid),
        .evt_ch    (evt_ch),
        .evt_ack   (evt_ack),
        .pend      (pend),
        .ovf       (ovf),
        .ovf_clr   (ovf_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_cmp++;
        assert (observed === expected) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_cycles(input int n);
        repeat (n) tick();
    endtask

    task automatic ack_once();
        evt_ack = 1'b1;
        tick();
        evt_ack = 1'b0;
    endtask

    task automatic clr_once();
        ovf_clr = 1'b1;
        tick();
        ovf_clr = 1'b0;
    endtask

    task automatic check_state(input string tag, input logic [3:0] exp_pend, input logic [3:0] exp_ovf,
                               input logic exp_valid, input logic [1:0] exp_ch);
        check({tag, "_pend"},  32'(pend),      32'(exp_pend));
        check({tag, "_ovf"},   32'(ovf),       32'(exp_ovf));
        check({tag, "_valid"}, 32'(evt_valid), 32'(exp_valid));
        check({tag, "_ch"},    32'(evt_ch),    32'(exp_ch));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_cmp    = 0;
        n_err    = 0;
        rst      = 1'b1;
        async_in = '0;
        evt_ack  = 1'b0;
        ovf_clr  = 1'b0;

        // Reset then idle
        wait_cycles(3);
        rst = 1'b0;
        check_state("reset", 4'b0000, 4'b0000, 1'b0, 2'd0);
        for (int i = 0; i < 20; i++) begin
            tick();
            check_state("idle", 4'b0000, 4'b0000, 1'b0, 2'd0);
        end

        // Ack with nothing pending is ignored
        ack_once();
        check_state("ack_idle", 4'b0000, 4'b0000, 1'b0, 2'd0);

        // Latency: rise before edge 1, pending after edge 3
        async_in[1] = 1'b1;
        tick();
        check("lat_e1_pend", 32'(pend), 32'(4'b0000));
        tick();
        check("lat_e2_pend", 32'(pend), 32'(4'b0000));
        tick();
        check_state("lat_e3", 4'b0010, 4'b0000, 1'b1, 2'd1);
        ack_once();
        check_state("lat_ack", 4'b0000, 4'b0000, 1'b0, 2'd0);
        async_in[1] = 1'b0;
        wait_cycles(4);
`ifdef DMI_CDC_TOGGLE_MODE_EN
        check_state("lat_fall_evt", 4'b0010, 4'b0000, 1'b1, 2'd1);
        ack_once();
`endif
        check_state("lat_idle", 4'b0000, 4'b0000, 1'b0, 2'd0);

        // Priority: channels 2 and 0 together
        async_in[2] = 1'b1;
        async_in[0] = 1'b1;
        wait_cycles(3);
        check_state("prio_both", 4'b0101, 4'b0000, 1'b1, 2'd0);
        ack_once();
        check_state("prio_ack1", 4'b0100, 4'b0000, 1'b1, 2'd2);
        ack_once();
        check_state("prio_ack2", 4'b0000, 4'b0000, 1'b0, 2'd0);
        async_in[2] = 1'b0;
        async_in[0] = 1'b0;
        wait_cycles(4);
`ifdef DMI_CDC_TOGGLE_MODE_EN
        check_state("prio_fall", 4'b0101, 4'b0000, 1'b1, 2'd0);
        ack_once();
        ack_once();
`endif
        check_state("prio_idle", 4'b0000, 4'b0000, 1'b0, 2'd0);

        // Overflow: two rising edges on ch0 without ack
        async_in[0] = 1'b1;
        wait_cycles(8);
        check("ovf_first_pend", 32'(pend), 32'(4'b0001));
        check("ovf_first_ovf",  32'(ovf),  32'(4'b0000));
        async_in[0] = 1'b0;
        wait_cycles(8);
        async_in[0] = 1'b1;
        wait_cycles(8);
        check_state("ovf_set", 4'b0001, 4'b0001, 1'b1, 2'd0);
        clr_once();
        check_state("ovf_clr", 4'b0001, 4'b0000, 1'b1, 2'd0);

        // Overflow set on the same edge as ovf_clr must win
        async_in[0] = 1'b0;
        wait_cycles(4);
        clr_once();
        check("race_pre_ovf", 32'(ovf), 32'(4'b0000));
        async_in[0] = 1'b1;
        wait_cycles(2);
        clr_once();
        check_state("race_set_wins", 4'b0001, 4'b0001, 1'b1, 2'd0);
        clr_once();
        check("race_clr_ovf", 32'(ovf), 32'(4'b0000));
        ack_once();
        check_state("race_idle", 4'b0000, 4'b0000, 1'b0, 2'd0);

        // Simultaneous ack and new event on ch0
`ifdef DMI_CDC_TOGGLE_MODE_EN
        async_in[0] = 1'b0;
        wait_cycles(3);
`else
        async_in[0] = 1'b0;
        wait_cycles(4);
        async_in[0] = 1'b1;
        wait_cycles(3);
        async_in[0] = 1'b0;
        wait_cycles(4);
`endif
        check_state("sim_pre", 4'b0001, 4'b0000, 1'b1, 2'd0);
        async_in[0] = 1'b1;
        wait_cycles(2);
        check("sim_mid_pend", 32'(pend), 32'(4'b0001));
        ack_once();
        check_state("sim_ack_evt", 4'b0001, 4'b0000, 1'b1, 2'd0);
        ack_once();
        check_state("sim_retire", 4'b0000, 4'b0000, 1'b0, 2'd0);

        // Reset mid-operation with ch2 held high
`ifdef DMI_CDC_TOGGLE_MODE_EN
        async_in[0] = 1'b0;
        async_in[2] = 1'b1;
        wait_cycles(3);
`else
        async_in[0] = 1'b0;
        wait_cycles(4);
        async_in[0] = 1'b1;
        async_in[2] = 1'b1;
        wait_cycles(3);
`endif
        check_state("rstmid_pre", 4'b0101, 4'b0000, 1'b1, 2'd0);
        rst         = 1'b1;
        async_in[0] = 1'b0;
        tick();
        rst = 1'b0;
        check_state("rstmid_clear", 4'b0000, 4'b0000, 1'b0, 2'd0);
        tick();
        check("rstmid_e1_pend", 32'(pend), 32'(4'b0000));
        tick();
        check("rstmid_e2_pend", 32'(pend), 32'(4'b0000));
        tick();
        check_state("rstmid_e3", 4'b0100, 4'b0000, 1'b1, 2'd2);
        wait_cycles(4);
        check_state("rstmid_hold", 4'b0100, 4'b0000, 1'b1, 2'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
